// File: rtl/pulse_generator_if.sv
// pulse_generator_if: control, configuration and status bundle of the
// programmable pulse-train generator. The master side issues run requests
// and configuration strobes. The slave side is the generator itself.
interface pulse_generator_if #(
  parameter int CNT_W   = 32,
  parameter int BURST_W = 16
);
  logic               enable;
  logic               cfg_load;
  logic [CNT_W-1:0]   cfg_high;
  logic [CNT_W-1:0]   cfg_low;
  logic [BURST_W-1:0] cfg_burst;
  logic               signal_out;
  logic               period_done;
  logic               burst_done;
  logic               busy;
  logic               cfg_pending;

  modport master (
    output enable, cfg_load, cfg_high, cfg_low, cfg_burst,
    input  signal_out, period_done, burst_done, busy, cfg_pending
  );

  modport slave (
    input  enable, cfg_load, cfg_high, cfg_low, cfg_burst,
    output signal_out, period_done, burst_done, busy, cfg_pending
  );
endinterface

// File: rtl/pulse_generator.sv
// pulse_generator: emits a train of high/low phases, either continuously or
// as a burst of a fixed number of periods. New configurations sit in a
// pending register and are only adopted at period boundaries, which keeps
// runt pulses off the output. signal_out, period_done and burst_done are
// registered one cycle behind the state machine, so period_done always lines
// up with the last low cycle that is visible on signal_out.
module pulse_generator #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int CNT_W      = 32,
  parameter int BURST_W    = 16
) (
  input logic              clk,
  input logic              rst,
  pulse_generator_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [BURST_W-1:0] BURST_ONE = {{(BURST_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BURST_W-1:0] perCnt_q, perCnt_d;
  logic [CNT_W-1:0]   actHigh_q, actHigh_d;
  logic [CNT_W-1:0]   actLow_q, actLow_d;
  logic [BURST_W-1:0] actBurst_q, actBurst_d;
  logic [CNT_W-1:0]   pendHigh_q, pendHigh_d;
  logic [CNT_W-1:0]   pendLow_q, pendLow_d;
  logic [BURST_W-1:0] pendBurst_q, pendBurst_d;
  logic               pendValid_q, pendValid_d;
  logic               signalOut_q;
  logic               periodDone_q;
  logic               burstDone_q;

  logic               periodEnd;
  logic               burstEnd;
  logic               startPeriod;
  logic [BURST_W-1:0] perInc;
  logic [CNT_W-1:0]   srcHigh;
  logic [CNT_W-1:0]   srcLow;
  logic [BURST_W-1:0] srcBurst;
  logic [CNT_W-1:0]   effLow;

  // Configuration that the next period would run with. In IDLE a strobe on
  // the same cycle is taken directly; otherwise pending wins over active.
  always_comb begin
    srcHigh  = actHigh_q;
    srcLow   = actLow_q;
    srcBurst = actBurst_q;
    if ((state_q == IDLE) && bus.cfg_load) begin
      srcHigh  = bus.cfg_high;
      srcLow   = bus.cfg_low;
      srcBurst = bus.cfg_burst;
    end else if (pendValid_q) begin
      srcHigh  = pendHigh_q;
      srcLow   = pendLow_q;
      srcBurst = pendBurst_q;
    end
    // H=0,L=0 would be a zero-length period; it is run as H=0,L=1 instead.
    effLow = ((srcHigh == '0) && (srcLow == '0)) ? CNT_ONE : srcLow;
  end

  // Next-state logic: phase countdown, period/burst bookkeeping and
  // adoption of the pending configuration at period starts.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    perCnt_d    = perCnt_q;
    actHigh_d   = actHigh_q;
    actLow_d    = actLow_q;
    actBurst_d  = actBurst_q;
    pendHigh_d  = pendHigh_q;
    pendLow_d   = pendLow_q;
    pendBurst_d = pendBurst_q;
    pendValid_d = pendValid_q;
    periodEnd   = 1'b0;
    burstEnd    = 1'b0;
    startPeriod = 1'b0;
    perInc      = perCnt_q + BURST_ONE;

    if (bus.cfg_load) begin
      pendHigh_d  = bus.cfg_high;
      pendLow_d   = bus.cfg_low;
      pendBurst_d = bus.cfg_burst;
      pendValid_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.enable) begin
          startPeriod = 1'b1;
          perCnt_d    = '0;
        end
      end
      HIGH: begin
        if (cnt_q == '0) begin
          if (actLow_q != '0) begin
            state_d = LOW;
            cnt_d   = actLow_q - CNT_ONE;
          end else begin
            periodEnd = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      LOW: begin
        if (cnt_q == '0) begin
          periodEnd = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (periodEnd) begin
      perCnt_d = perInc;
      if ((actBurst_q != '0) && (perInc == actBurst_q)) begin
        burstEnd = 1'b1;
        state_d  = IDLE;
      end else if (!bus.enable) begin
        state_d = IDLE;
      end else begin
        startPeriod = 1'b1;
      end
    end

    if (startPeriod) begin
      actHigh_d   = srcHigh;
      actLow_d    = effLow;
      actBurst_d  = srcBurst;
      // A strobe landing on a running period boundary stays pending for one
      // more period; a strobe in IDLE has just been consumed.
      pendValid_d = bus.cfg_load && (state_q != IDLE);
      if (srcHigh == '0) begin
        state_d = LOW;
        cnt_d   = effLow - CNT_ONE;
      end else begin
        state_d = HIGH;
        cnt_d   = srcHigh - CNT_ONE;
      end
    end
  end

  // State, counters and configuration registers; reset restores the 1/1
  // continuous default and overrides any simultaneous strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      perCnt_q    <= '0;
      actHigh_q   <= CNT_ONE;
      actLow_q    <= CNT_ONE;
      actBurst_q  <= '0;
      pendHigh_q  <= CNT_ONE;
      pendLow_q   <= CNT_ONE;
      pendBurst_q <= '0;
      pendValid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      perCnt_q    <= perCnt_d;
      actHigh_q   <= actHigh_d;
      actLow_q    <= actLow_d;
      actBurst_q  <= actBurst_d;
      pendHigh_q  <= pendHigh_d;
      pendLow_q   <= pendLow_d;
      pendBurst_q <= pendBurst_d;
      pendValid_q <= pendValid_d;
    end
  end

  // Registered waveform and event strobes, one cycle behind the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      signalOut_q  <= 1'b0;
      periodDone_q <= 1'b0;
      burstDone_q  <= 1'b0;
    end else begin
      signalOut_q  <= (state_q == HIGH);
      periodDone_q <= periodEnd;
      burstDone_q  <= burstEnd;
    end
  end

  assign bus.signal_out  = signalOut_q;
  assign bus.period_done = periodDone_q;
  assign bus.burst_done  = burstDone_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.cfg_pending = pendValid_q;

endmodule

// File: tb/tb_pulse_generator.sv
// tb_pulse_generator: directed bench for pulse_generator. Each scenario
// records signal_out, period_done, burst_done and busy one bit per cycle
// (oldest bit leftmost) and compares the traces against hand-derived
// patterns.
module tb_pulse_generator;

  logic clk;
  logic rst;

  pulse_generator_if #(.CNT_W(32), .BURST_W(16)) ifc ();

  pulse_generator #(
    .CLOCK_FREQ(50000000),
    .CNT_W(32),
    .BURST_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  int checkCount = 0;
  int failCount  = 0;

  logic [63:0] sigV;
  logic [63:0] pdV;
  logic [63:0] bdV;
  logic [63:0] busyV;

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic clearVectors();
    sigV  = '0;
    pdV   = '0;
    bdV   = '0;
    busyV = '0;
  endtask

  task automatic setCfg(input logic [31:0] h, input logic [31:0] l,
                        input logic [15:0] b);
    ifc.cfg_high  = h;
    ifc.cfg_low   = l;
    ifc.cfg_burst = b;
    ifc.cfg_load  = 1'b1;
  endtask

  // Advance n cycles, sampling 1 ns after each rising edge; any strobe is
  // dropped after the first edge.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      ifc.cfg_load = 1'b0;
      sigV  = {sigV[62:0], ifc.signal_out};
      pdV   = {pdV[62:0], ifc.period_done};
      bdV   = {bdV[62:0], ifc.burst_done};
      busyV = {busyV[62:0], ifc.busy};
    end
  endtask

  task automatic waitIdle();
    int cyc;
    cyc = 0;
    ifc.enable = 1'b0;
    while (ifc.busy && (cyc < 64)) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (ifc.busy) checkOutput("idleTimeout", 64'(ifc.busy), 64'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    ifc.enable    = 1'b0;
    ifc.cfg_load  = 1'b0;
    ifc.cfg_high  = '0;
    ifc.cfg_low   = '0;
    ifc.cfg_burst = '0;
    clearVectors();
    applyStimulus(2);
    checkOutput("rstSignal", 64'(ifc.signal_out), 64'd0);
    checkOutput("rstPeriodDone", 64'(ifc.period_done), 64'd0);
    checkOutput("rstBurstDone", 64'(ifc.burst_done), 64'd0);
    checkOutput("rstBusy", 64'(ifc.busy), 64'd0);
    checkOutput("rstPending", 64'(ifc.cfg_pending), 64'd0);
    rst = 1'b0;
    applyStimulus(1);

    $display("[TB] basic period 3/2 continuous");
    setCfg(32'd3, 32'd2, 16'd0);
    applyStimulus(1);
    checkOutput("basicPendingSet", 64'(ifc.cfg_pending), 64'd1);
    checkOutput("basicIdleBusy", 64'(ifc.busy), 64'd0);
    clearVectors();
    ifc.enable = 1'b1;
    applyStimulus(16);
    checkOutput("basicSig", sigV, 64'b0111001110011100);
    checkOutput("basicPd", pdV, 64'b0000010000100001);
    checkOutput("basicBusy", busyV, 64'b1111111111111111);
    checkOutput("basicPendingClr", 64'(ifc.cfg_pending), 64'd0);
    waitIdle();

    $display("[TB] burst 2/2 x3 with restart");
    setCfg(32'd2, 32'd2, 16'd3);
    ifc.enable = 1'b1;
    clearVectors();
    applyStimulus(16);
    checkOutput("burstSig", sigV, 64'b0110011001100011);
    checkOutput("burstPd", pdV, 64'b0000100010001000);
    checkOutput("burstBd", bdV, 64'b0000000000001000);
    checkOutput("burstBusy", busyV, 64'b1111111111110111);
    waitIdle();

    $display("[TB] mid-run reconfig 4/4 -> 1/7");
    setCfg(32'd4, 32'd4, 16'd0);
    ifc.enable = 1'b1;
    clearVectors();
    applyStimulus(4);
    setCfg(32'd1, 32'd7, 16'd0);
    applyStimulus(1);
    checkOutput("reconfPendingA", 64'(ifc.cfg_pending), 64'd1);
    applyStimulus(3);
    checkOutput("reconfPendingB", 64'(ifc.cfg_pending), 64'd1);
    applyStimulus(1);
    checkOutput("reconfPendingClr", 64'(ifc.cfg_pending), 64'd0);
    applyStimulus(11);
    checkOutput("reconfSig", sigV, 64'b01111000010000000100);
    checkOutput("reconfPd", pdV, 64'b00000000100000001000);
    waitIdle();

    $display("[TB] degenerate H=0 L=5");
    setCfg(32'd0, 32'd5, 16'd0);
    ifc.enable = 1'b1;
    clearVectors();
    applyStimulus(16);
    checkOutput("h0Sig", sigV, 64'b0000000000000000);
    checkOutput("h0Pd", pdV, 64'b0000010000100001);
    waitIdle();

    $display("[TB] degenerate H=5 L=0");
    setCfg(32'd5, 32'd0, 16'd0);
    ifc.enable = 1'b1;
    clearVectors();
    applyStimulus(16);
    checkOutput("l0Sig", sigV, 64'b0111111111111111);
    checkOutput("l0Pd", pdV, 64'b0000010000100001);
    waitIdle();

    $display("[TB] degenerate H=0 L=0");
    setCfg(32'd0, 32'd0, 16'd0);
    ifc.enable = 1'b1;
    clearVectors();
    applyStimulus(16);
    checkOutput("h0l0Sig", sigV, 64'b0000000000000000);
    checkOutput("h0l0Pd", pdV, 64'b0111111111111111);
    waitIdle();

    $display("[TB] clean stop 6/6");
    setCfg(32'd6, 32'd6, 16'd0);
    ifc.enable = 1'b1;
    clearVectors();
    applyStimulus(3);
    ifc.enable = 1'b0;
    applyStimulus(14);
    checkOutput("stopSig", sigV, 64'b01111110000000000);
    checkOutput("stopPd", pdV, 64'b00000000000010000);
    checkOutput("stopBusy", busyV, 64'b11111111111100000);
    waitIdle();

    $display("[TB] reset mid-run");
    setCfg(32'd3, 32'd2, 16'd0);
    ifc.enable = 1'b1;
    clearVectors();
    applyStimulus(3);
    rst = 1'b1;
    setCfg(32'd9, 32'd9, 16'd0);
    applyStimulus(1);
    checkOutput("midRstSig", 64'(ifc.signal_out), 64'd0);
    checkOutput("midRstBusy", 64'(ifc.busy), 64'd0);
    checkOutput("midRstPd", 64'(ifc.period_done), 64'd0);
    checkOutput("midRstPending", 64'(ifc.cfg_pending), 64'd0);
    rst = 1'b0;
    clearVectors();
    applyStimulus(8);
    checkOutput("postRstSig", sigV, 64'b01010101);
    checkOutput("postRstPd", pdV, 64'b00101010);
    waitIdle();

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
